// File: rtl/seg_display_pkg.sv
// Shared codes, segment patterns and converter state type for the seven-segment scan display.
package seg_display_pkg;

   localparam logic [3:0]  DIG_DASH  = 4'hA;
   localparam logic [3:0]  DIG_BLANK = 4'hF;
   localparam logic [15:0] OVF_LIMIT = 16'd9999;

   // Active-low, ordered {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {CV_IDLE, CV_SHIFT, CV_LOAD} conv_state_e;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:     return SEG_0;
         4'd1:     return SEG_1;
         4'd2:     return SEG_2;
         4'd3:     return SEG_3;
         4'd4:     return SEG_4;
         4'd5:     return SEG_5;
         4'd6:     return SEG_6;
         4'd7:     return SEG_7;
         4'd8:     return SEG_8;
         4'd9:     return SEG_9;
         DIG_DASH: return SEG_DASH;
         default:  return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary to four BCD nibbles in 16 shift cycles plus one LOAD cycle.
module bin2bcd_seq
   import seg_display_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [15:0]      bin_in,
   output logic             busy,
   output logic             done,
   output logic [3:0][3:0]  bcd
);

   conv_state_e state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] bin_q, bin_d;
   logic [15:0] bcd_q, bcd_d;
   logic [15:0] adj;

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < 4; i++)
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      case (state_q)
         CV_IDLE: if (start) begin
            bin_d   = bin_in;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = CV_SHIFT;
         end
         CV_SHIFT: begin
            {bcd_d, bin_d} = {adj[14:0], bin_q, 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) state_d = CV_LOAD;
         end
         CV_LOAD: state_d = CV_IDLE;
         default: state_d = CV_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CV_IDLE;
         cnt_q   <= '0;
         bin_q   <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
      end
   end

   assign busy = (state_q != CV_IDLE);
   assign done = (state_q == CV_LOAD);
   assign bcd  = bcd_q;

endmodule

// File: rtl/seg_scan_display.sv
// 4-digit multiplexed common-anode display driver with once-per-frame BCD conversion.
// Optional SEG_BLANK_LEADING_ZERO_EN blanks leading zero digits at LOAD.
module seg_scan_display
   import seg_display_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int SCAN_HZ = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [15:0] value_in,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        conv_busy
);

   localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
   localparam int TW       = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [TW-1:0]    tick_q, tick_d;
   logic [1:0]       idx_q, idx_d;
   logic             pend_q, pend_d;
   logic             ovf_q, ovf_d;
   logic [3:0][3:0]  dig_q, dig_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             tick, frame_start, upd;
   logic             busy, done;
   logic [3:0][3:0]  bcd;

   assign tick        = enable && (tick_q == TICK_LAST);
   // pend_q marks "first tick after enable/reset still owed a frame start"
   assign frame_start = tick && (idx_q == 2'd3 || pend_q);
   assign upd         = enable && (tick || pend_q);

   bin2bcd_seq u_conv (
      .clk    (clk),
      .rst    (rst),
      .start  (frame_start),
      .bin_in (value_in),
      .busy   (busy),
      .done   (done),
      .bcd    (bcd)
   );

   always_comb begin
      tick_d = !enable ? '0 : (tick ? '0 : tick_q + 1'b1);
      idx_d  = !enable ? 2'd0 : (tick ? idx_q + 2'd1 : idx_q);
      pend_d = !enable ? 1'b1 : (tick ? 1'b0 : pend_q);
      ovf_d  = (frame_start && !busy) ? (value_in > OVF_LIMIT) : ovf_q;
      dig_d  = dig_q;
      if (done) begin
         if (ovf_q) begin
            dig_d = {4{DIG_DASH}};
         end else begin
            dig_d = bcd;
`ifdef SEG_BLANK_LEADING_ZERO_EN
            for (int i = 3; i >= 1; i--) begin
               if (bcd[i] != 4'd0) break;
               dig_d[i] = DIG_BLANK;
            end
`endif
         end
      end
      an_d  = an_q;
      seg_d = seg_q;
      if (!enable) begin
         an_d  = 4'hF;
         seg_d = SEG_BLANK;
      end else if (upd) begin
         an_d  = ~(4'b0001 << idx_d);
         seg_d = seg_decode(dig_q[idx_d]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q <= '0;
         idx_q  <= '0;
         pend_q <= 1'b1;
         ovf_q  <= 1'b0;
         dig_q  <= '0;
         an_q   <= 4'hF;
         seg_q  <= SEG_BLANK;
      end else begin
         tick_q <= tick_d;
         idx_q  <= idx_d;
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
         dig_q  <= dig_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
      end
   end

   assign an        = an_q;
   assign seg       = seg_q;
   assign dp        = 1'b1;
   assign conv_busy = busy;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: vector table, random values vs. arithmetic model, corner sequences.
module tb_seg_scan_display;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000,
                          S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000,
                          S8 = 7'b0000000, S9 = 7'b0010000, SD = 7'b0111111, SB = 7'b1111111;
`ifdef SEG_BLANK_LEADING_ZERO_EN
   localparam logic [6:0] Z = SB;
`else
   localparam logic [6:0] Z = S0;
`endif

   logic        clk = 1'b0;
   logic        rst, enable;
   logic [15:0] value_in;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp, conv_busy;
   int          total = 0, bad = 0;

   typedef struct packed {
      logic [15:0]      v;
      logic [3:0][6:0]  s;   // s[0] = ones digit
   } vec_t;
   vec_t tbl[8];

   seg_scan_display #(.CLK_HZ(1000), .SCAN_HZ(100)) dut (
      .clk(clk), .rst(rst), .enable(enable), .value_in(value_in),
      .an(an), .seg(seg), .dp(dp), .conv_busy(conv_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] pat(input int d);
      case (d)
         0: return S0; 1: return S1; 2: return S2; 3: return S3; 4: return S4;
         5: return S5; 6: return S6; 7: return S7; 8: return S8; default: return S9;
      endcase
   endfunction

   function automatic logic [6:0] model_seg(input int v, input int d);
      int p = 1;
      for (int k = 0; k < d; k++) p = p * 10;
      if (v > 9999) return SD;
`ifdef SEG_BLANK_LEADING_ZERO_EN
      if (d > 0 && v < p) return SB;
`endif
      return pat((v / p) % 10);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_busy(input logic lvl, input string nm, output int n);
      n = 0;
      while (conv_busy !== lvl && n < 200) begin step(); n++; end
      if (conv_busy !== lvl) chk({nm, "_timeout"}, 32'(conv_busy), 32'(lvl));
   endtask

   task automatic wait_an(input logic [3:0] a, input string nm);
      int n = 0;
      while (an !== a && n < 100) begin step(); n++; end
      if (an !== a) chk({nm, "_timeout"}, 32'(an), 32'(a));
   endtask

   task automatic check_frame(input logic [3:0][6:0] exp, input string nm);
      wait_an(4'b1110, nm);
      for (int d = 0; d < 4; d++) begin
         wait_an(~(4'b0001 << d), nm);
         chk($sformatf("%s_seg%0d", nm, d), 32'(seg), 32'(exp[d]));
      end
      chk({nm, "_dp"}, 32'(dp), 32'd1);
   endtask

   task automatic check_value(input logic [15:0] v, input logic [3:0][6:0] exp, input string nm);
      int n;
      wait_busy(1'b0, nm, n);
      value_in = v;
      wait_busy(1'b1, nm, n);
      wait_busy(1'b0, nm, n);
      chk({nm, "_busylen"}, 32'(n), 32'd17);
      check_frame(exp, nm);
   endtask

   initial begin
      logic [3:0][6:0] e;
      int n, v;

      tbl[0] = '{16'd1234,  {S1, S2, S3, S4}};
      tbl[1] = '{16'd10000, {SD, SD, SD, SD}};
      tbl[2] = '{16'd7,     {Z,  Z,  Z,  S7}};
      tbl[3] = '{16'd0,     {Z,  Z,  Z,  S0}};
      tbl[4] = '{16'd9999,  {S9, S9, S9, S9}};
      tbl[5] = '{16'd65535, {SD, SD, SD, SD}};
      tbl[6] = '{16'd50,    {Z,  Z,  S5, S0}};
      tbl[7] = '{16'd1005,  {S1, S0, S0, S5}};

      rst = 1'b1; enable = 1'b0; value_in = '0;
      repeat (3) step();
      chk("rst_an",   32'(an),        32'hF);
      chk("rst_seg",  32'(seg),       32'h7F);
      chk("rst_dp",   32'(dp),        32'd1);
      chk("rst_busy", 32'(conv_busy), 32'd0);
      rst = 1'b0; enable = 1'b1;

      for (int i = 0; i < 8; i++)
         check_value(tbl[i].v, tbl[i].s, $sformatf("tbl%0d", i));

      for (int i = 0; i < 18; i++) begin
         case (i % 3)
            0: v = int'($urandom_range(99));
            1: v = int'($urandom_range(9999));
            default: v = int'($urandom_range(65535));
         endcase
         for (int d = 0; d < 4; d++) e[d] = model_seg(v, d);
         check_value(16'(v), e, $sformatf("rnd%0d_v%0d", i, v));
      end

      // value change mid-frame is not seen until the LOAD after the next frame start
      for (int d = 0; d < 4; d++) e[d] = model_seg(42, d);
      check_value(16'd42, e, "v42");
      wait_busy(1'b1, "mid", n);
      value_in = 16'd99;
      wait_busy(1'b0, "mid", n);
      wait_an(4'b1110, "mid");
      chk("mid_keep_d0", 32'(seg), 32'(model_seg(42, 0)));
      wait_an(4'b1101, "mid");
      chk("mid_keep_d1", 32'(seg), 32'(model_seg(42, 1)));
      wait_busy(1'b0, "mid", n);
      for (int d = 0; d < 4; d++) e[d] = model_seg(99, d);
      check_frame(e, "mid_new");

      // enable drop mid-scan, then restart at digit 0 with a conversion on the first tick
      wait_an(4'b1011, "en");
      repeat (3) step();
      enable = 1'b0;
      step();
      chk("dis_an",  32'(an),  32'hF);
      chk("dis_seg", 32'(seg), 32'h7F);
      repeat (20) step();
      chk("dis_hold_an", 32'(an), 32'hF);
      chk("dis_busy",    32'(conv_busy), 32'd0);
      enable = 1'b1;
      step();
      chk("reen_an", 32'(an), 32'hE);
      n = 1;
      while (!conv_busy && n < 50) begin step(); n++; end
      chk("reen_conv_cycle", 32'(n), 32'd10);
      chk("reen_an_adv", 32'(an), 32'hD);
      wait_busy(1'b0, "reen", n);
      check_frame(e, "reen");

      // reset during SHIFT aborts conversion and clears digits
      for (int d = 0; d < 4; d++) e[d] = model_seg(8888, d);
      check_value(16'd8888, e, "v8888");
      wait_busy(1'b1, "rs", n);
      repeat (3) step();
      rst = 1'b1;
      step();
      chk("rs_busy", 32'(conv_busy), 32'd0);
      chk("rs_an",   32'(an),        32'hF);
      rst = 1'b0;
      step();
      chk("rs_an0",  32'(an),  32'hE);
      chk("rs_seg0", 32'(seg), 32'(S0));
      wait_an(4'b1101, "rs");
      chk("rs_seg1", 32'(seg), 32'(S0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Consumer end of the game score/display interface: takes the 16-bit binary display value from a game-logic block (for example the infinity-mode score output) and drives a 4-digit multiplexed common-anode seven-segment display. The binary value is converted to BCD with a sequential double-dabble engine once per scan frame. The digits are then time-multiplexed at a fixed refresh rate. The block sits between the game-logic mux and the board display pins.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency.
- `SCAN_HZ`, default 1000: digit-advance rate. `CLK_HZ/SCAN_HZ` must be ≥ 5.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `enable` in 1: display on. When low, the display is blanked and the scan is held.
- `value_in` in 16: unsigned binary value to display. Sampled once per frame.
- `an` out 4: digit anodes, active-low. `an[0]` is the ones digit.
- `seg` out 7: segment cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- `dp` out 1: decimal point, active-low. Always 1 (off).
- `conv_busy` out 1: high while a BCD conversion is in progress.

## Operation
- Tick counter: counts 0..`CLK_HZ/SCAN_HZ`-1 and wraps. Its wrap cycle is the scan tick.
- Digit index: a 2-bit counter that advances on each scan tick, 0→1→2→3→0.
- Frame start: the scan tick on which the index wraps 3→0. Frame start also occurs on the first tick after `enable` rises.
- Converter FSM states:
  - IDLE: on frame start, latch `value_in` into the shift register, clear the BCD register, go to SHIFT.
  - SHIFT: 16 cycles. Each cycle, add 3 to every BCD nibble ≥ 5, then shift the combined {bcd,bin} register left by 1. Go to LOAD after the 16th shift.
  - LOAD: copy the BCD result into the four display-digit registers in a single cycle, then return to IDLE.
- Overflow: if the latched value is > 9999, LOAD writes the dash code (10) to all four digit registers.
- Segment decode:
  - Nibbles 0–9 use the standard patterns.
  - Nibble 10 is a dash (`seg`=7'b0111111).
  - Nibble 15 is blank (7'b1111111).
- Digit drive: `an` = ~(1 << index). `seg` is the decode of the digit register at that index.
- `enable` low:
  - `an`=4'b1111 and `seg`=7'b1111111.
  - The tick counter and index are held at 0.
  - A conversion already in progress completes.
  - Digit registers are retained.

## Timing
- Reset values:
  - `an`=4'b1111, `seg`=7'b1111111, `dp`=1, `conv_busy`=0.
  - Tick counter, index, FSM (IDLE) and all digit registers are 0.
- Outputs are registered. `an` and `seg` change one cycle after the scan tick.
- Conversion latency: `conv_busy` rises the cycle after frame start and stays high for 17 cycles (16 SHIFT + 1 LOAD). Digit registers update at the end of LOAD.
- The new value first appears on the next digit tick after LOAD, i.e. within one frame after sampling.
- Changes to `value_in` outside the frame-start cycle are ignored until the next frame start.
- Frame start while a conversion is busy cannot occur, since the frame is at least 20 cycles and conversion takes 17. The FSM ignores a start request while not in IDLE.
- `rst` mid-conversion aborts it: FSM goes to IDLE and digit registers clear to 0.
- `enable` falling and a scan tick in the same cycle: `enable` wins and the index is held at 0.

## Configuration
- `SEG_BLANK_LEADING_ZERO_EN`:
  - Defined: at LOAD, zero digits more significant than the highest nonzero digit are written as blank (15). Digit 0 is always shown. Dash fill is unaffected.
  - Undefined: all four digits are shown, including leading zeros.

## Structure
- Package `seg_display_pkg` holds:
  - Nibble codes `DIG_DASH`=4'hA and `DIG_BLANK`=4'hF.
  - The active-low segment pattern constants for 0–9, dash and blank.
  - The `OVF_LIMIT`=9999 constant.
- Sub-module `bin2bcd_seq`: start/busy/done double-dabble engine (16-bit in, four 4-bit BCD nibbles out). The top level holds the scan counters, overflow check, blanking and decode.

## Test plan
All scenarios use `CLK_HZ`=1000 and `SCAN_HZ`=100, so a tick occurs every 10 cycles.
- Reset, then `enable`=1, `value_in`=1234 → after one frame, `an` cycles 1110/1101/1011/0111 with `seg` showing 4/3/2/1. `conv_busy` is high for exactly 17 cycles.
- `value_in`=10000 → all digits show dash, `seg`=7'b0111111 on every `an`.
- `value_in`=7 with macro defined → digit 0 shows 7 and digits 1–3 are `seg`=7'b1111111. Without the macro, digits 1–3 show 0 (`seg`=7'b1000000).
- `value_in` changes 42→99 mid-frame → the display keeps 42 until the LOAD following the next frame start, then shows 99.
- `enable` dropped mid-scan → the next cycle `an`=4'b1111. On re-enable the scan restarts at digit 0 and a conversion starts on the first tick.
- Assert `rst` during SHIFT → the next cycle FSM is IDLE, `conv_busy`=0, and the digit registers read 0.
